// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition encodings,
// FSM state type and default datapath width.
package branch_resolve_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from Rs1-Rs2 via the CLA subtractor.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    logic [XLEN-1:0] diff;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic            sign_diff;

    cla_subtractor #(.W(XLEN)) u_sub (
        .a    (rs1),
        .b    (rs2),
        .en   (1'b1),
        .diff (diff)
    );

    // Signed compare corrects the difference sign on overflow; unsigned
    // compare falls back on Rs2's MSB when the operand MSBs differ.
    assign sign_diff = rs1[XLEN-1] ^ rs2[XLEN-1];
    assign eq        = (diff == '0);
    assign lt        = diff[XLEN-1] ^ (sign_diff & (diff[XLEN-1] ^ rs1[XLEN-1]));
    assign ltu       = sign_diff ? rs2[XLEN-1] : diff[XLEN-1];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (is_jal || is_jalr) begin
            taken = 1'b1;
        end else begin
            case (funct3)
                BEQ:     taken = eq;
                BNE:     taken = ~eq;
                BLT:     taken = lt;
                BGE:     taken = ~lt;
                BLTU:    taken = ltu;
                BGEU:    taken = ~ltu;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/cla_subtractor.sv
// Carry-lookahead adder/subtractor: diff = a - b when en=1, a + b otherwise.
// Lookahead inside 4-bit groups, groups rippled; W must be a multiple of 4.
module cla_subtractor #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         en,
    output logic [W-1:0] diff
);

    logic [W-1:0] b_eff;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;

    assign b_eff = en ? ~b : b;
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;
    assign c[0]  = en;

    for (genvar gi = 0; gi < W / 4; gi++) begin : g_blk
        localparam int B = gi * 4;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        // The final group's carry-out is not needed by anything downstream.
        if (gi < W / 4 - 1) begin : g_cout
            assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B])
                          | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
        end
    end

    assign diff = p ^ c;

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 holds the issued uop, S2 holds the result;
// a mispredict starts a fixed-length flush that squashes younger uops.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       funct3_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [XLEN-1:0]  Rs1_i,
    input  logic [XLEN-1:0]  Rs2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_tgt_i,
    output logic             valid_o,
    output logic             taken_o,
    output logic [XLEN-1:0]  redirect_o,
    output logic             flush_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    fsm_state_t      state, state_next;
    logic [FC_W-1:0] flush_cnt, flush_cnt_next;

    logic            s1_valid;
    logic [2:0]      s1_funct3;
    logic            s1_is_jal;
    logic            s1_is_jalr;
    logic [XLEN-1:0] s1_rs1;
    logic [XLEN-1:0] s1_rs2;
    logic [XLEN-1:0] s1_pc;
    logic [XLEN-1:0] s1_imm;
    logic            s1_pred_taken;
    logic [XLEN-1:0] s1_pred_tgt;

    logic            cond_taken;
    logic            cond_illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic            mispredict;
    logic            accept;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .funct3  (s1_funct3),
        .is_jal  (s1_is_jal),
        .is_jalr (s1_is_jalr),
        .rs1     (s1_rs1),
        .rs2     (s1_rs2),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign ready_o = (state == RUN);
    assign flush_o = (state == FLUSH);
    assign accept  = valid_i & ready_o;

    always_comb begin
        target = s1_pc + s1_imm;
        if (s1_is_jalr) begin
            target = (s1_rs1 + s1_imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end
        seq_pc     = s1_pc + XLEN'(4);
        mispredict = s1_valid & ((cond_taken != s1_pred_taken) |
                                 (cond_taken & (target != s1_pred_tgt)));
    end

    // The FSM enters FLUSH on the same edge the mispredicting result reaches S2,
    // so flush_o rises together with valid_o and lasts FLUSH_CYC cycles.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FC_W'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - FC_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // A uop accepted on the mispredict edge is younger and gets dropped.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_funct3     <= '0;
            s1_is_jal     <= 1'b0;
            s1_is_jalr    <= 1'b0;
            s1_rs1        <= '0;
            s1_rs2        <= '0;
            s1_pc         <= '0;
            s1_imm        <= '0;
            s1_pred_taken <= 1'b0;
            s1_pred_tgt   <= '0;
        end else begin
            s1_valid <= accept & ~mispredict;
            if (accept) begin
                s1_funct3     <= funct3_i;
                s1_is_jal     <= is_jal_i;
                s1_is_jalr    <= is_jalr_i;
                s1_rs1        <= Rs1_i;
                s1_rs2        <= Rs2_i;
                s1_pc         <= pc_i;
                s1_imm        <= imm_i;
                s1_pred_taken <= pred_taken_i;
                s1_pred_tgt   <= pred_tgt_i;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            taken_o    <= 1'b0;
            illegal_o  <= 1'b0;
            redirect_o <= '0;
            br_cnt_o   <= '0;
            mis_cnt_o  <= '0;
        end else begin
            valid_o   <= s1_valid;
            taken_o   <= s1_valid & cond_taken;
            illegal_o <= s1_valid & cond_illegal;
            if (s1_valid) begin
                redirect_o <= cond_taken ? target : seq_pc;
            end
            if (s1_valid && (br_cnt_o != '1)) begin
                br_cnt_o <= br_cnt_o + CNT_W'(1);
            end
            if (mispredict && (mis_cnt_o != '1)) begin
                mis_cnt_o <= mis_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
